// File: rtl/cpu_ctl_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, FSM states,
// bit positions within the miscellaneous control bus and the decoded step record.
package cpu_ctl_pkg;

  localparam int CTL_W = 22;
  localparam int OP_W  = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_JAL  = 5'b10100;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10101;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11001;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  localparam logic [OP_W-1:0] ALU_ADD = OP_ADD;

  typedef enum logic [2:0] {FETCH0, FETCH1, FETCH2, EXEC, HALT} state_t;

  localparam int C_PCOUT     = 0;
  localparam int C_PCIN      = 1;
  localparam int C_INCPC     = 2;
  localparam int C_MARIN     = 3;
  localparam int C_MDRIN     = 4;
  localparam int C_MDROUT    = 5;
  localparam int C_IRIN      = 6;
  localparam int C_YIN       = 7;
  localparam int C_ZIN       = 8;
  localparam int C_ZLOWOUT   = 9;
  localparam int C_ZHIGHOUT  = 10;
  localparam int C_HIIN      = 11;
  localparam int C_LOIN      = 12;
  localparam int C_HIOUT     = 13;
  localparam int C_LOOUT     = 14;
  localparam int C_COUT      = 15;
  localparam int C_CONIN     = 16;
  localparam int C_READ      = 17;
  localparam int C_WRITE     = 18;
  localparam int C_INPORTOUT = 19;
  localparam int C_OUTPORTIN = 20;
  localparam int C_R15IN     = 21;

  typedef struct packed {
    logic             gra;
    logic             grb;
    logic             grc;
    logic             rin;
    logic             rout;
    logic             baout;
    logic [CTL_W-1:0] ctl;
    logic [OP_W-1:0]  alu_op;
    logic             last;
  } step_ctl_t;

endpackage

// File: rtl/ctl_step_decode.sv
// Combinational execute-phase decoder: (opcode, step, CON_FF) to datapath strobes
// and a flag marking the final step of the instruction.
module ctl_step_decode
  import cpu_ctl_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic [2:0]      step,
  input  logic            con_ff,
  output step_ctl_t       dec
);

  // The last step of each sequence sits in the default arm so no step can run away.
  always_comb begin
    dec = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROL, OP_ROR, OP_SHL, OP_SHR, OP_SHRA:
        case (step)
          3'd3: begin dec.grb = 1'b1; dec.rout = 1'b1; dec.ctl[C_YIN] = 1'b1; end
          3'd4: begin dec.grc = 1'b1; dec.rout = 1'b1; dec.ctl[C_ZIN] = 1'b1; end
          default: begin dec.gra = 1'b1; dec.rin = 1'b1; dec.ctl[C_ZLOWOUT] = 1'b1; dec.last = 1'b1; end
        endcase
      OP_ADDI, OP_ANDI, OP_ORI:
        case (step)
          3'd3: begin dec.grb = 1'b1; dec.rout = 1'b1; dec.ctl[C_YIN] = 1'b1; end
          3'd4: begin dec.ctl[C_COUT] = 1'b1; dec.ctl[C_ZIN] = 1'b1; end
          default: begin dec.gra = 1'b1; dec.rin = 1'b1; dec.ctl[C_ZLOWOUT] = 1'b1; dec.last = 1'b1; end
        endcase
      OP_NEG, OP_NOT:
        case (step)
          3'd3: begin dec.grb = 1'b1; dec.rout = 1'b1; dec.ctl[C_ZIN] = 1'b1; end
          default: begin dec.gra = 1'b1; dec.rin = 1'b1; dec.ctl[C_ZLOWOUT] = 1'b1; dec.last = 1'b1; end
        endcase
      OP_MUL, OP_DIV:
        case (step)
          3'd3: begin dec.gra = 1'b1; dec.rout = 1'b1; dec.ctl[C_YIN] = 1'b1; end
          3'd4: begin dec.grb = 1'b1; dec.rout = 1'b1; dec.ctl[C_ZIN] = 1'b1; end
          3'd5: begin dec.ctl[C_ZLOWOUT] = 1'b1; dec.ctl[C_LOIN] = 1'b1; end
          default: begin dec.ctl[C_ZHIGHOUT] = 1'b1; dec.ctl[C_HIIN] = 1'b1; dec.last = 1'b1; end
        endcase
      OP_LD, OP_LDI, OP_ST:
        case (step)
          3'd3: begin dec.grb = 1'b1; dec.baout = 1'b1; dec.ctl[C_YIN] = 1'b1; end
          3'd4: begin dec.ctl[C_COUT] = 1'b1; dec.ctl[C_ZIN] = 1'b1; end
          3'd5: begin
            dec.ctl[C_ZLOWOUT] = 1'b1;
            if (opcode == OP_LDI) begin
              dec.gra  = 1'b1;
              dec.rin  = 1'b1;
              dec.last = 1'b1;
            end else begin
              dec.ctl[C_MARIN] = 1'b1;
            end
          end
          3'd6: begin
            dec.ctl[C_MDRIN] = 1'b1;
            if (opcode == OP_LD) begin
              dec.ctl[C_READ] = 1'b1;
            end else begin
              dec.gra  = 1'b1;
              dec.rout = 1'b1;
            end
          end
          default: begin
            if (opcode == OP_LD) begin
              dec.ctl[C_MDROUT] = 1'b1;
              dec.gra = 1'b1;
              dec.rin = 1'b1;
            end else begin
              dec.ctl[C_WRITE] = 1'b1;
            end
            dec.last = 1'b1;
          end
        endcase
      OP_BR:
        case (step)
          3'd3: begin dec.gra = 1'b1; dec.rout = 1'b1; dec.ctl[C_CONIN] = 1'b1; end
          3'd4: begin dec.ctl[C_PCOUT] = 1'b1; dec.ctl[C_YIN] = 1'b1; end
          3'd5: begin dec.ctl[C_COUT] = 1'b1; dec.ctl[C_ZIN] = 1'b1; end
          default: begin
            dec.ctl[C_ZLOWOUT] = con_ff;
            dec.ctl[C_PCIN]    = con_ff;
            dec.last           = 1'b1;
          end
        endcase
      OP_JR: begin dec.gra = 1'b1; dec.rout = 1'b1; dec.ctl[C_PCIN] = 1'b1; dec.last = 1'b1; end
      OP_JAL:
        case (step)
          3'd3: begin dec.ctl[C_PCOUT] = 1'b1; dec.ctl[C_R15IN] = 1'b1; end
          default: begin dec.gra = 1'b1; dec.rout = 1'b1; dec.ctl[C_PCIN] = 1'b1; dec.last = 1'b1; end
        endcase
      OP_IN:   begin dec.gra = 1'b1; dec.rin = 1'b1; dec.ctl[C_INPORTOUT] = 1'b1; dec.last = 1'b1; end
      OP_OUT:  begin dec.gra = 1'b1; dec.rout = 1'b1; dec.ctl[C_OUTPORTIN] = 1'b1; dec.last = 1'b1; end
      OP_MFHI: begin dec.gra = 1'b1; dec.rin = 1'b1; dec.ctl[C_HIOUT] = 1'b1; dec.last = 1'b1; end
      OP_MFLO: begin dec.gra = 1'b1; dec.rin = 1'b1; dec.ctl[C_LOOUT] = 1'b1; dec.last = 1'b1; end
      default: dec.last = 1'b1;
    endcase

    if (dec.ctl[C_ZIN]) begin
      if (opcode == OP_LD || opcode == OP_LDI || opcode == OP_ST || opcode == OP_BR) begin
        dec.alu_op = ALU_ADD;
      end else begin
        dec.alu_op = opcode;
      end
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle Moore control unit: fetch FSM, execute step counter and halt/run state.
// Define MEM_WAIT_EN to stall memory steps on mem_ready; otherwise they take one cycle.
module control_sequencer
  import cpu_ctl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      IR,
  input  logic             CON_FF,
  input  logic             mem_ready,
  input  logic             stop,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic [CTL_W-1:0] ctl,
  output logic [OP_W-1:0]  alu_op,
  output logic             run
);

  state_t    state, state_nx;
  logic [2:0] step, step_nx;
  logic      waiting, waiting_nx;
  logic      mem_ok;
  logic      stall;
  step_ctl_t dec;
  step_ctl_t raw;
  logic      unused_ir;

  assign unused_ir = ^IR[26:0];

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  ctl_step_decode u_decode (
    .opcode (IR[31:27]),
    .step   (step),
    .con_ff (CON_FF),
    .dec    (dec)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= FETCH0;
      step    <= 3'd0;
      waiting <= 1'b0;
    end else begin
      state   <= state_nx;
      step    <= step_nx;
      waiting <= waiting_nx;
    end
  end

  // The PC increment in FETCH0 is presented to the ALU as an add.
  always_comb begin
    raw = '0;
    case (state)
      FETCH0: begin
        raw.ctl[C_PCOUT] = 1'b1;
        raw.ctl[C_MARIN] = 1'b1;
        raw.ctl[C_INCPC] = 1'b1;
        raw.ctl[C_ZIN]   = 1'b1;
        raw.alu_op       = ALU_ADD;
      end
      FETCH1: begin
        raw.ctl[C_ZLOWOUT] = 1'b1;
        raw.ctl[C_PCIN]    = 1'b1;
        raw.ctl[C_READ]    = 1'b1;
        raw.ctl[C_MDRIN]   = 1'b1;
      end
      FETCH2: begin
        raw.ctl[C_MDROUT] = 1'b1;
        raw.ctl[C_IRIN]   = 1'b1;
      end
      EXEC:    raw = dec;
      default: raw = '0;
    endcase
  end

  // stop is only honoured where an instruction would otherwise return to FETCH0.
  always_comb begin
    stall      = (raw.ctl[C_READ] | raw.ctl[C_WRITE]) & ~mem_ok;
    state_nx   = state;
    step_nx    = step;
    waiting_nx = 1'b0;
    case (state)
      FETCH0: state_nx = FETCH1;
      FETCH1: begin
        if (stall) waiting_nx = 1'b1;
        else       state_nx   = FETCH2;
      end
      FETCH2: begin
        state_nx = EXEC;
        step_nx  = 3'd3;
      end
      EXEC: begin
        if (stall) begin
          waiting_nx = 1'b1;
        end else if (IR[31:27] == OP_HALT) begin
          state_nx = HALT;
          step_nx  = 3'd0;
        end else if (raw.last) begin
          state_nx = stop ? HALT : FETCH0;
          step_nx  = 3'd0;
        end else begin
          step_nx = step + 3'd1;
        end
      end
      HALT:    state_nx = HALT;
      default: state_nx = FETCH0;
    endcase
  end

  // While waiting on memory only Read/Write and the MDR capture stay asserted.
  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    ctl    = '0;
    alu_op = '0;
    if (!reset) begin
      if (waiting) begin
        ctl[C_READ]  = raw.ctl[C_READ];
        ctl[C_WRITE] = raw.ctl[C_WRITE];
        ctl[C_MDRIN] = raw.ctl[C_MDRIN];
      end else begin
        Gra    = raw.gra;
        Grb    = raw.grb;
        Grc    = raw.grc;
        Rin    = raw.rin;
        Rout   = raw.rout;
        BAout  = raw.baout;
        ctl    = raw.ctl;
        alu_op = raw.alu_op;
      end
    end
  end

  assign run = reset | (state != HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a per-instruction step table expands into
// expected cycle words that a negedge monitor compares against the DUT outputs.
module tb_control_sequencer;
  import cpu_ctl_pkg::*;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      IR = '0;
  logic             CON_FF = 1'b0;
  logic             mem_ready = 1'b1;
  logic             stop = 1'b0;
  logic             Gra, Grb, Grc, Rin, Rout, BAout;
  logic [CTL_W-1:0] ctl;
  logic [OP_W-1:0]  alu_op;
  logic             run;

  typedef struct packed {
    logic             gra;
    logic             grb;
    logic             grc;
    logic             rin;
    logic             rout;
    logic             baout;
    logic [CTL_W-1:0] ctl;
    logic [OP_W-1:0]  alu_op;
    logic             run;
  } obs_t;

  typedef struct {
    obs_t w;
    bit   mem;
  } step_t;

  localparam obs_t RESET_W = obs_t'(34'd1);
  localparam obs_t HALT_W  = obs_t'(34'd0);

  localparam logic [5:0] SA = 6'b100000;
  localparam logic [5:0] SB = 6'b010000;
  localparam logic [5:0] SC = 6'b001000;
  localparam logic [5:0] SI = 6'b000100;
  localparam logic [5:0] SO = 6'b000010;
  localparam logic [5:0] SX = 6'b000001;

  obs_t  expq[$];
  string lblq[$];
  step_t prog[$];
  int    checks = 0;
  int    failures = 0;

  control_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .IR        (IR),
    .CON_FF    (CON_FF),
    .mem_ready (mem_ready),
    .stop      (stop),
    .Gra       (Gra),
    .Grb       (Grb),
    .Grc       (Grc),
    .Rin       (Rin),
    .Rout      (Rout),
    .BAout     (BAout),
    .ctl       (ctl),
    .alu_op    (alu_op),
    .run       (run)
  );

  always #5 clock = ~clock;

  function automatic logic [CTL_W-1:0] cb(input int idx);
    return CTL_W'(1) << idx;
  endfunction

  function automatic step_t mk(input logic [5:0] sel, input logic [CTL_W-1:0] c, input bit mem);
    step_t s;
    s.w = '0;
    {s.w.gra, s.w.grb, s.w.grc, s.w.rin, s.w.rout, s.w.baout} = sel;
    s.w.ctl = c;
    s.w.run = 1'b1;
    s.mem   = mem;
    return s;
  endfunction

  function automatic obs_t held(input obs_t w);
    obs_t h;
    h = '0;
    h.run          = 1'b1;
    h.ctl[C_READ]  = w.ctl[C_READ];
    h.ctl[C_WRITE] = w.ctl[C_WRITE];
    h.ctl[C_MDRIN] = w.ctl[C_MDRIN];
    return h;
  endfunction

  task automatic add_step(input logic [5:0] sel, input logic [CTL_W-1:0] c, input bit mem);
    prog.push_back(mk(sel, c, mem));
  endtask

  // Full list of cycle words for one instruction, fetch included, before any waiting.
  task automatic build_steps(input logic [4:0] op, input logic con);
    prog.delete();
    add_step(6'b0, cb(C_PCOUT) | cb(C_MARIN) | cb(C_INCPC) | cb(C_ZIN), 1'b0);
    add_step(6'b0, cb(C_ZLOWOUT) | cb(C_PCIN) | cb(C_READ) | cb(C_MDRIN), 1'b1);
    add_step(6'b0, cb(C_MDROUT) | cb(C_IRIN), 1'b0);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROL, OP_ROR, OP_SHL, OP_SHR, OP_SHRA: begin
        add_step(SB | SO, cb(C_YIN), 1'b0);
        add_step(SC | SO, cb(C_ZIN), 1'b0);
        add_step(SA | SI, cb(C_ZLOWOUT), 1'b0);
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        add_step(SB | SO, cb(C_YIN), 1'b0);
        add_step(6'b0, cb(C_COUT) | cb(C_ZIN), 1'b0);
        add_step(SA | SI, cb(C_ZLOWOUT), 1'b0);
      end
      OP_NEG, OP_NOT: begin
        add_step(SB | SO, cb(C_ZIN), 1'b0);
        add_step(SA | SI, cb(C_ZLOWOUT), 1'b0);
      end
      OP_MUL, OP_DIV: begin
        add_step(SA | SO, cb(C_YIN), 1'b0);
        add_step(SB | SO, cb(C_ZIN), 1'b0);
        add_step(6'b0, cb(C_ZLOWOUT) | cb(C_LOIN), 1'b0);
        add_step(6'b0, cb(C_ZHIGHOUT) | cb(C_HIIN), 1'b0);
      end
      OP_LD, OP_LDI, OP_ST: begin
        add_step(SB | SX, cb(C_YIN), 1'b0);
        add_step(6'b0, cb(C_COUT) | cb(C_ZIN), 1'b0);
        if (op == OP_LDI) begin
          add_step(SA | SI, cb(C_ZLOWOUT), 1'b0);
        end else begin
          add_step(6'b0, cb(C_ZLOWOUT) | cb(C_MARIN), 1'b0);
          if (op == OP_LD) begin
            add_step(6'b0, cb(C_READ) | cb(C_MDRIN), 1'b1);
            add_step(SA | SI, cb(C_MDROUT), 1'b0);
          end else begin
            add_step(SA | SO, cb(C_MDRIN), 1'b0);
            add_step(6'b0, cb(C_WRITE), 1'b1);
          end
        end
      end
      OP_BR: begin
        add_step(SA | SO, cb(C_CONIN), 1'b0);
        add_step(6'b0, cb(C_PCOUT) | cb(C_YIN), 1'b0);
        add_step(6'b0, cb(C_COUT) | cb(C_ZIN), 1'b0);
        add_step(6'b0, con ? (cb(C_ZLOWOUT) | cb(C_PCIN)) : CTL_W'(0), 1'b0);
      end
      OP_JR:   add_step(SA | SO, cb(C_PCIN), 1'b0);
      OP_JAL: begin
        add_step(6'b0, cb(C_PCOUT) | cb(C_R15IN), 1'b0);
        add_step(SA | SO, cb(C_PCIN), 1'b0);
      end
      OP_IN:   add_step(SA | SI, cb(C_INPORTOUT), 1'b0);
      OP_OUT:  add_step(SA | SO, cb(C_OUTPORTIN), 1'b0);
      OP_MFHI: add_step(SA | SI, cb(C_HIOUT), 1'b0);
      OP_MFLO: add_step(SA | SI, cb(C_LOOUT), 1'b0);
      default: add_step(6'b0, CTL_W'(0), 1'b0);
    endcase
    foreach (prog[i]) begin
      if (prog[i].w.ctl[C_ZIN]) begin
        if (i == 0 || op == OP_LD || op == OP_LDI || op == OP_ST || op == OP_BR)
          prog[i].w.alu_op = ALU_ADD;
        else
          prog[i].w.alu_op = op;
      end
    end
  endtask

  task automatic apply_stimulus(input obs_t w, input logic rdy, input logic rst, input string name);
    reset     = rst;
    mem_ready = rdy;
    expq.push_back(w);
    lblq.push_back(name);
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input obs_t act, input obs_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Plays one instruction; abort_at picks a cycle at which reset is asserted instead.
  task automatic run_instr(input logic [4:0] op, input logic con, input bit stp,
                           input int dly, input int abort_at);
    int   cyc;
    int   n;
    obs_t w;
    bit   halting;
    cyc = 0;
    build_steps(op, con);
    IR      = {op, 27'($urandom)};
    CON_FF  = con;
    halting = stp || (op == OP_HALT);
    foreach (prog[i]) begin
      stop = stp && (i >= 4 || i == prog.size() - 1);
      n = 1;
`ifdef MEM_WAIT_EN
      if (prog[i].mem) n = dly + 1;
`endif
      for (int c = 0; c < n; c++) begin
        if (cyc == abort_at) begin
          stop = 1'b0;
          apply_stimulus(RESET_W, 1'b1, 1'b1, $sformatf("op%05b/abort%0d", op, cyc));
          return;
        end
        w = (c == 0) ? prog[i].w : held(prog[i].w);
        apply_stimulus(w, prog[i].mem ? (c >= dly) : 1'($urandom & 1), 1'b0,
                       $sformatf("op%05b/cyc%0d", op, cyc));
        cyc++;
      end
    end
    stop = 1'b0;
    if (halting) begin
      repeat (10) apply_stimulus(HALT_W, 1'($urandom & 1), 1'b0, $sformatf("op%05b/halted", op));
      apply_stimulus(RESET_W, 1'b1, 1'b1, "halt_reset");
    end
  endtask

  always @(negedge clock) begin
    if (expq.size() > 0) begin
      check_output(lblq.pop_front(), {Gra, Grb, Grc, Rin, Rout, BAout, ctl, alu_op, run},
                   expq.pop_front());
    end
  end

  initial begin
    @(posedge clock);
    #1;
    apply_stimulus(RESET_W, 1'b1, 1'b1, "reset0");
    apply_stimulus(RESET_W, 1'b1, 1'b1, "reset1");

    run_instr(OP_ADD, 1'b0, 1'b0, 0, -1);
    run_instr(OP_LD, 1'b0, 1'b0, 3, -1);
    run_instr(OP_BR, 1'b0, 1'b0, 0, -1);
    run_instr(OP_BR, 1'b1, 1'b0, 0, -1);
    run_instr(OP_HALT, 1'b0, 1'b0, 0, -1);
    run_instr(OP_SUB, 1'b0, 1'b1, 0, -1);
    run_instr(OP_ST, 1'b0, 1'b0, 0, 6);
    run_instr(OP_ST, 1'b1, 1'b0, 2, -1);
    run_instr(5'b11110, 1'b0, 1'b0, 0, -1);

    for (int k = 0; k < 80; k++) begin
      run_instr(5'($urandom_range(0, 31)), 1'($urandom & 1), ($urandom_range(0, 9) == 0),
                $urandom_range(0, 3), ($urandom_range(0, 11) == 0) ? $urandom_range(0, 9) : -1);
    end

    @(posedge clock);
    #1;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain pending=%0d required=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
